// File: rtl/pid_fitness_scorer_if.sv
// Beat/result handshake bundle for pid_fitness_scorer.
// master: test-case source and result sink; slave: the scorer.
interface pid_fitness_scorer_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [15:0]      y3, y2, y1, y0;
  logic [15:0]      e3, e2, e1, e0;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_err;
  logic [CNT_W-1:0] out_cases;
  logic             out_perfect;
  logic             out_sat;

  modport master (
    output in_valid, in_last,
    output y3, y2, y1, y0,
    output e3, e2, e1, e0,
    output out_ready,
    input  in_ready,
    input  out_valid, out_err, out_cases,
    input  out_perfect, out_sat
  );

  modport slave (
    input  in_valid, in_last,
    input  y3, y2, y1, y0,
    input  e3, e2, e1, e0,
    input  out_ready,
    output in_ready,
    output out_valid, out_err, out_cases,
    output out_perfect, out_sat
  );
endinterface

// File: rtl/pid_fitness_scorer.sv
// Accumulates per-beat Hamming error of y3..y0 vs e3..e0 over a batch.
// Ports: clk, rst_n (sync, active-low), bus (slave): beats in, batch result out.
module pid_fitness_scorer #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  pid_fitness_scorer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_err_q;
  logic [CNT_W-1:0] out_cases_q;
  logic             out_perfect_q;
  logic             out_sat_q;

  logic [63:0]      diff;
  logic [6:0]       hd;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  logic             cnt_full;
  logic             in_ready;
  logic             take;

  function automatic logic [6:0] pop64(
    input logic [63:0] v
  );
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++)
      c = c + {6'd0, v[i]};
    return c;
  endfunction

  assign in_ready = rst_n && (state_q != REPORT);
  assign take     = bus.in_valid && in_ready;

  assign diff = {bus.y3, bus.y2, bus.y1, bus.y0}
              ^ {bus.e3, bus.e2, bus.e1, bus.e0};

  always_comb begin
    hd       = pop64(diff);
    // one spare bit catches the carry that triggers the clamp
    acc_sum  = {1'b0, acc_q} + {{(ACC_W-6){1'b0}}, hd};
    acc_ovf  = acc_sum[ACC_W];
    acc_d    = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
    cnt_full = &cnt_q;
    cnt_d    = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
    sat_d    = sat_q | acc_ovf | cnt_full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_err_q     <= '0;
      out_cases_q   <= '0;
      out_perfect_q <= 1'b0;
      out_sat_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (take && bus.in_last) begin
            out_err_q     <= acc_d;
            out_cases_q   <= cnt_d;
            out_sat_q     <= sat_d;
            out_perfect_q <= (acc_d == '0) && !sat_d;
            out_valid_q   <= 1'b1;
            acc_q         <= '0;
            cnt_q         <= '0;
            sat_q         <= 1'b0;
            state_q       <= REPORT;
          end else if (take) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            state_q <= ACCUM;
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_err     = out_err_q;
  assign bus.out_cases   = out_cases_q;
  assign bus.out_perfect = out_perfect_q;
  assign bus.out_sat     = out_sat_q;

endmodule
